multi_pb_latch: RTL and testbench

MULTI_PB_LATCH -- requirements
Module: multi_pb_latch

---
 rtl/tow_pkg.sv | 16 +
 rtl/pb_sync_edge.sv | 39 +++
 rtl/multi_pb_latch.sv | 126 ++++++++++++
 tb/tb_multi_pb_latch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types for the multi-player push-button latch: FSM states and the
// winner-index width helper.
package tow_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WINDOW  = 2'd1,
        LATCHED = 2'd2
    } state_t;

    // Winner index width: max(1, clog2(n)) so a 2-player build still gets a bit.
    function automatic int winner_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pb_sync_edge.sv
// One push-button channel: SYNC_STAGES-deep synchronizer plus rising-edge
// detector. A channel only becomes armed after a genuine low level has been
// seen at the synchronizer output, so a button held through reset cannot
// masquerade as a fresh press once the zeroed flops refill.
module pb_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] fill;   // marks which sync stages hold a real sample
    logic                   prev;
    logic                   armed;
    logic                   level;

    assign level = sync[SYNC_STAGES-1];

    // Synchronizer chain, fill tracker, previous level and arm flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            fill  <= '0;
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], pb};
            fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
            prev  <= level;
            armed <= armed | (fill[SYNC_STAGES-1] & ~level);
        end
    end

    assign rise = level & ~prev & armed;

endmodule

// File: rtl/multi_pb_latch.sv
// Multi-player push-button latch: first press opens an optional tie window,
// then the round latches push/tie/winner/pressed until clear or rst.
module multi_pb_latch
    import tow_pkg::*;
#(
    parameter int  N_PLAYERS   = 2,
    parameter int  SYNC_STAGES = 2,
    parameter int  TIE_WINDOW  = 2,
    localparam int W           = winner_width(N_PLAYERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_PLAYERS-1:0] pb,
    input  logic                 clear,
    output logic                 push,
    output logic                 tie,
    output logic [W-1:0]         winner,
    output logic [N_PLAYERS-1:0] pressed
);

    localparam int CW = 4;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   push_nxt, tie_nxt;
    logic [W-1:0]           winner_nxt;
    logic [N_PLAYERS-1:0]   pressed_nxt;
    logic [N_PLAYERS-1:0]   rise;
    logic [N_PLAYERS-1:0]   merged;

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_ch
        pb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
            .clk  (clk),
            .rst  (rst),
            .pb   (pb[i]),
            .rise (rise[i])
        );
    end

    // Lowest set index; used to pick the winner among same-cycle first presses.
    function automatic logic [W-1:0] lowest_set(input logic [N_PLAYERS-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--)
            if (v[i]) idx = W'(i);
        return idx;
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [N_PLAYERS-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < N_PLAYERS; i++)
            n = n + CW'(v[i]);
        return n;
    endfunction

    assign merged = pressed | rise;

    // State and round registers; rst wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            push    <= 1'b0;
            tie     <= 1'b0;
            winner  <= '0;
            pressed <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            push    <= push_nxt;
            tie     <= tie_nxt;
            winner  <= winner_nxt;
            pressed <= pressed_nxt;
        end
    end

    // Next-state and round bookkeeping; clear discards any same-cycle press.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        push_nxt    = push;
        tie_nxt     = tie;
        winner_nxt  = winner;
        pressed_nxt = pressed;
        if (clear) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            push_nxt    = 1'b0;
            tie_nxt     = 1'b0;
            winner_nxt  = '0;
            pressed_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|rise) begin
                        pressed_nxt = rise;
                        winner_nxt  = lowest_set(rise);
                        if (popcount(rise) > CW'(1) || TIE_WINDOW == 0) begin
                            state_nxt = LATCHED;
                            push_nxt  = 1'b1;
                            tie_nxt   = popcount(rise) > CW'(1);
                        end else begin
                            state_nxt = WINDOW;
                            cnt_nxt   = CW'(TIE_WINDOW);
                        end
                    end
                end
                WINDOW: begin
                    // Presses in the closing cycle still count toward the tie.
                    pressed_nxt = merged;
                    cnt_nxt     = cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state_nxt = LATCHED;
                        push_nxt  = 1'b1;
                        tie_nxt   = popcount(merged) > CW'(1);
                    end
                end
                LATCHED: begin
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_pb_latch.sv
// Bench for multi_pb_latch: a 2-player default build and a 4-player build
// with no tie window. Expected rounds are queued when stimulus is driven and
// popped when push rises.
module tb_multi_pb_latch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [1:0] pb2 = '0;
    logic [3:0] pb4 = '0;
    logic       push2, tie2, push4, tie4;
    logic [0:0] winner2;
    logic [1:0] winner4;
    logic [1:0] pressed2;
    logic [3:0] pressed4;

    typedef struct packed {
        logic [7:0] lat;
        logic       tie;
        logic [1:0] winner;
        logic [3:0] pressed;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] stim[16];
    int         checks = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    multi_pb_latch d2 (
        .clk(clk), .rst(rst), .pb(pb2), .clear(clear),
        .push(push2), .tie(tie2), .winner(winner2), .pressed(pressed2)
    );

    multi_pb_latch #(.N_PLAYERS(4), .SYNC_STAGES(2), .TIE_WINDOW(0)) d4 (
        .clk(clk), .rst(rst), .pb(pb4), .clear(clear),
        .push(push4), .tie(tie4), .winner(winner4), .pressed(pressed4)
    );

    function automatic logic [6:0] obs(input bit big);
        return big ? {tie4, winner4, pressed4}
                   : {tie2, 1'b0, winner2, 2'b00, pressed2};
    endfunction

    function automatic logic [6:0] vec(input exp_t e);
        return {e.tie, e.winner, e.pressed};
    endfunction

    // Drive stim[] one entry per cycle from a negedge; lat = edge count at
    // which push is first seen (edge 1 is the first to sample stim[0]).
    task automatic run(input bit big, output int lat);
        lat = -1;
        if (big) pb4 = stim[0]; else pb2 = stim[0][1:0];
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k < 16) begin
                if (big) pb4 = stim[k]; else pb2 = stim[k][1:0];
            end
            if ((big ? push4 : push2) === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1; pb2 = '0; pb4 = '0;
        @(negedge clk); clear = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({push2, obs(0)} !== 8'h00)
            $display("FAIL reset_d2 got %h want 00", {push2, obs(0)});
        else passed++;
        checks++;
        if ({push4, obs(1)} !== 8'h00)
            $display("FAIL reset_d4 got %h want 00", {push4, obs(1)});
        else passed++;
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int lat; exp_t e;
        stim = '{default: '0};
        for (int i = 0; i < 3; i++) stim[i] = 4'b0010;
        sbq.push_back('{lat: 8'd5, tie: 1'b0, winner: 2'd1, pressed: 4'b0010});
        run(0, lat);
        pb2 = '0;
        e = sbq.pop_front();
        checks++;
        if (lat !== int'(e.lat)) $display("FAIL single_lat got %0d want %0d", lat, e.lat);
        else passed++;
        checks++;
        if (obs(0) !== vec(e)) $display("FAIL single_res got %h want %h", obs(0), vec(e));
        else passed++;
        repeat (4) @(negedge clk);
        checks++;
        if ({push2, obs(0)} !== {1'b1, vec(e)})
            $display("FAIL single_hold got %h want %h", {push2, obs(0)}, {1'b1, vec(e)});
        else passed++;
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({push2, obs(0)} !== 8'h00) $display("FAIL single_clear got %h want 00", {push2, obs(0)});
        else passed++;
        @(negedge clk); clear = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_tie_window();
        int lat; exp_t e;
        // pb[1] first sampled two edges after pb[0]: inside the window.
        stim = '{default: '0};
        stim[0] = 4'b01; stim[1] = 4'b01; stim[2] = 4'b11; stim[3] = 4'b11;
        sbq.push_back('{lat: 8'd5, tie: 1'b1, winner: 2'd0, pressed: 4'b0011});
        run(0, lat);
        pb2 = '0;
        e = sbq.pop_front();
        checks++;
        if (lat !== int'(e.lat)) $display("FAIL tie_in_lat got %0d want %0d", lat, e.lat);
        else passed++;
        checks++;
        if (obs(0) !== vec(e)) $display("FAIL tie_in_res got %h want %h", obs(0), vec(e));
        else passed++;
        do_clear();
        // Three edges later: too late, ignored once latched.
        stim = '{default: '0};
        stim[0] = 4'b01; stim[1] = 4'b01; stim[2] = 4'b01;
        for (int i = 3; i < 8; i++) stim[i] = 4'b11;
        sbq.push_back('{lat: 8'd5, tie: 1'b0, winner: 2'd0, pressed: 4'b0001});
        run(0, lat);
        e = sbq.pop_front();
        checks++;
        if (lat !== int'(e.lat)) $display("FAIL tie_late_lat got %0d want %0d", lat, e.lat);
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (obs(0) !== vec(e)) $display("FAIL tie_late_res got %h want %h", obs(0), vec(e));
        else passed++;
        do_clear();
        // Player 1 first, player 0 one cycle later: winner is the first presser.
        stim = '{default: '0};
        stim[0] = 4'b10; stim[1] = 4'b11; stim[2] = 4'b11;
        sbq.push_back('{lat: 8'd5, tie: 1'b1, winner: 2'd1, pressed: 4'b0011});
        run(0, lat);
        pb2 = '0;
        e = sbq.pop_front();
        checks++;
        if ({lat[7:0], obs(0)} !== {e.lat, vec(e)})
            $display("FAIL tie_order got %h want %h", {lat[7:0], obs(0)}, {e.lat, vec(e)});
        else passed++;
        do_clear();
    endtask

    task automatic test_same_cycle();
        int lat; exp_t e;
        stim = '{default: '0};
        stim[0] = 4'b11; stim[1] = 4'b11;
        sbq.push_back('{lat: 8'd3, tie: 1'b1, winner: 2'd0, pressed: 4'b0011});
        run(0, lat);
        pb2 = '0;
        e = sbq.pop_front();
        checks++;
        if (lat !== int'(e.lat)) $display("FAIL same_lat got %0d want %0d", lat, e.lat);
        else passed++;
        checks++;
        if (obs(0) !== vec(e)) $display("FAIL same_res got %h want %h", obs(0), vec(e));
        else passed++;
        do_clear();
    endtask

    task automatic test_held_clear();
        int lat; exp_t e;
        @(negedge clk); clear = 1'b1; pb2 = 2'b01;
        repeat (4) @(negedge clk); clear = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if ({push2, pressed2} !== 3'b000) $display("FAIL held_clear got %b want 000", {push2, pressed2});
        else passed++;
        pb2 = '0;
        repeat (5) @(negedge clk);
        stim = '{default: '0};
        stim[0] = 4'b01; stim[1] = 4'b01;
        sbq.push_back('{lat: 8'd5, tie: 1'b0, winner: 2'd0, pressed: 4'b0001});
        run(0, lat);
        pb2 = '0;
        e = sbq.pop_front();
        checks++;
        if ({lat[7:0], obs(0)} !== {e.lat, vec(e)})
            $display("FAIL repress got %h want %h", {lat[7:0], obs(0)}, {e.lat, vec(e)});
        else passed++;
        do_clear();
    endtask

    task automatic test_reset_window();
        @(negedge clk); pb2 = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({push2, obs(0)} !== 8'h00) $display("FAIL rst_window got %h want 00", {push2, obs(0)});
        else passed++;
        @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({push2, pressed2} !== 3'b000) $display("FAIL rst_held got %b want 000", {push2, pressed2});
        else passed++;
        pb2 = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_four_players();
        int lat; exp_t e;
        stim = '{default: '0};
        stim[0] = 4'b1000; stim[1] = 4'b1000;
        sbq.push_back('{lat: 8'd3, tie: 1'b0, winner: 2'd3, pressed: 4'b1000});
        run(1, lat);
        pb4 = '0;
        e = sbq.pop_front();
        checks++;
        if (lat !== int'(e.lat)) $display("FAIL p4_lat got %0d want %0d", lat, e.lat);
        else passed++;
        checks++;
        if (obs(1) !== vec(e)) $display("FAIL p4_res got %h want %h", obs(1), vec(e));
        else passed++;
        repeat (2) @(negedge clk);
        pb4 = 4'b0010;
        repeat (3) @(negedge clk);
        pb4 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({push4, obs(1)} !== {1'b1, vec(e)})
            $display("FAIL p4_hold got %h want %h", {push4, obs(1)}, {1'b1, vec(e)});
        else passed++;
        do_clear();
        checks++;
        if ({push4, obs(1)} !== 8'h00) $display("FAIL p4_clear got %h want 00", {push4, obs(1)});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie_window();
        test_same_cycle();
        test_held_clear();
        test_reset_window();
        test_four_players();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
